// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the control word latched when an operation starts.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Everything the FIX cycle needs to turn magnitudes into the final result
  typedef struct packed {
    logic is_div;
    logic neg_a;
    logic neg_b;
    logic b_zero;
  } mdu_ctl_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Shift-add multiply / restoring divide datapath on unsigned magnitudes,
// one bit per enabled cycle. Result is {hi_o, lo_o} (product or rem/quotient).
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;
  logic [WIDTH:0]   sum, rem_sh, diff;

  // One iteration: add-and-shift-right for multiply, shift-left-and-subtract for divide
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    sum      = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_hi_d = diff;
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = rem_sh;
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_d = {1'b0, sum[WIDTH:1]};
      acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
    end else if (load_i) begin
      acc_hi_q <= '0;
      acc_lo_q <= div_i ? a_i : b_i;
      opnd_q   <= div_i ? b_i : a_i;
      div_q    <= div_i;
    end else if (en_i) begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  assign hi_o = acc_hi_q[WIDTH-1:0];
  assign lo_o = acc_lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO, sitting beside the ALU in EX.
// Holds the pipeline via busy while a MULT/DIV walks IDLE -> RUN (WIDTH cycles) -> FIX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q, a_q;
  mdu_ctl_t         ctl_q, ctl_d;

  logic             is_div, is_signed, is_arith, accept_c, load_c, step_c;
  logic [WIDTH-1:0] mag_a, mag_b, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

  // Request decode and operand magnitudes
  always_comb begin
    is_div       = (op == MDU_DIV) || (op == MDU_DIVU);
    is_signed    = (op == MDU_MULT) || (op == MDU_DIV);
    is_arith     = is_div || (op == MDU_MULT) || (op == MDU_MULTU);
    mag_a        = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b        = (is_signed && b[WIDTH-1]) ? -b : b;
    ctl_d        = '0;
    ctl_d.is_div = is_div;
    ctl_d.neg_a  = is_signed && a[WIDTH-1];
    ctl_d.neg_b  = is_signed && b[WIDTH-1];
    ctl_d.b_zero = (b == '0);
  end

  assign accept_c = (state_q == ST_IDLE) && start && !flush;
  assign load_c   = accept_c && is_arith;
  assign step_c   = (state_q == ST_RUN) && !flush;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_c),
    .en_i   (step_c),
    .div_i  (is_div),
    .a_i    (mag_a),
    .b_i    (mag_b),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  // Sign correction; divide-by-zero returns the latched dividend and an all-ones quotient
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = (ctl_q.neg_a ^ ctl_q.neg_b) ? -prod : prod;
    quo_fix  = (ctl_q.neg_a ^ ctl_q.neg_b) ? -core_lo : core_lo;
    rem_fix  = ctl_q.neg_a ? -core_hi : core_hi;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (ctl_q.is_div) begin
      res_hi = ctl_q.b_zero ? a_q : rem_fix;
      res_lo = ctl_q.b_zero ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      ctl_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (is_arith) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              a_q     <= a;
              ctl_q   <= ctl_d;
            end else if (op == MDU_MTHI) begin
              hi_q <= a;
            end else if (op == MDU_MTLO) begin
              lo_q <= a;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and random MULT/DIV/MTHI/MTLO traffic on a 32-bit
// and an 8-bit instance, checked against an arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic busy, done;
  logic start8 = 1'b0, flush8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0, hi8, lo8;
  logic busy8, done8;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] hm = '0, lm = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result of a w-bit operation using plain integer arithmetic
  function automatic void model(input int w, input logic [2:0] o, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] rh,
                                output logic [31:0] rl);
    logic [31:0] mask;
    logic [63:0] ua, ub, p;
    longint sa, sb, q, r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ua = 64'(av & mask);
    ub = 64'(bv & mask);
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    rh = '0;
    rl = '0;
    if (o == 3'd0 || o == 3'd1) begin
      p  = (o == 3'd0) ? 64'(sa * sb) : ua * ub;
      rl = 32'(p) & mask;
      rh = 32'(p >> w) & mask;
    end else if (ub == 64'd0) begin
      rh = av & mask;
      rl = mask;
    end else begin
      if (o == 3'd2) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
      end
      rl = 32'(q) & mask;
      rh = 32'(r) & mask;
    end
  endfunction

  // 32-bit MULT/DIV; optional flush at cycle fl_at or MTLO attempt at cycle inj_at
  task automatic run32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit chain, input int fl_at, input int inj_at);
    logic [31:0] eh, el;
    int n, nb;
    bit seen, both;
    model(32, o, av, bv, eh, el);
    if (fl_at > 0) begin
      eh = hm;
      el = lm;
    end
    if (!chain) @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    n = 0; nb = 0; seen = 1'b0; both = 1'b0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      flush = 1'b0;
      if (busy) nb++;
      if (busy && done) both = 1'b1;
      if (done) seen = 1'b1;
      if (n == fl_at) flush = 1'b1;
      if (n == inj_at) begin
        start = 1'b1; op = MDU_MTLO; a = 32'hDEAD_BEEF;
      end
    end while (n < 40 && !(seen && fl_at == 0));
    if (fl_at == 0) begin
      chk("latency", 64'(n), 64'(34));
      chk("busy_cycles", 64'(nb), 64'(33));
    end else begin
      chk("flush_busy_cycles", 64'(nb), 64'(fl_at));
      chk("flush_no_done", 64'(seen), 64'(0));
    end
    chk("done_busy_overlap", 64'(both), 64'(0));
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    hm = eh;
    lm = el;
  endtask

  // Single-edge request (MTHI/MTLO/reserved, or anything with flush) that must not raise busy
  task automatic mt32(input logic [2:0] o, input logic [31:0] av, input bit fl);
    @(negedge clk);
    start = 1'b1; op = o; a = av; flush = fl;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    if (!fl && o == 3'd4) hm = av;
    if (!fl && o == 3'd5) lm = av;
    @(negedge clk);
    chk("mt_hi", 64'(hi), 64'(hm));
    chk("mt_lo", 64'(lo), 64'(lm));
    chk("mt_busy", 64'(busy), 64'(0));
    chk("mt_done", 64'(done), 64'(0));
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input bit chain);
    logic [31:0] eh, el;
    int n, nb;
    model(8, o, 32'(av), 32'(bv), eh, el);
    if (!chain) @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = av; b8 = bv;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
    end while (!done8 && n < 30);
    chk("w8_latency", 64'(n), 64'(10));
    chk("w8_busy_cycles", 64'(nb), 64'(9));
    chk("w8_busy_at_done", 64'(busy8), 64'(0));
    chk("w8_hi", 64'(hi8), 64'(eh[7:0]));
    chk("w8_lo", 64'(lo8), 64'(el[7:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] av, bv;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst = 1'b0;

    run32(MDU_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, 0, 0);
    run32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run32(MDU_DIVU,  32'd100,       32'd7,         1'b0, 0, 0);
    run32(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 0, 0);
    run32(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run32(MDU_DIVU,  32'h0000_1234, 32'd0,         1'b0, 0, 0);
    run32(MDU_DIV,   32'hFFFF_FFF0, 32'd0,         1'b0, 0, 0);

    mt32(MDU_MTHI, 32'hAAAA_5555, 1'b0);
    mt32(MDU_MTLO, 32'h1234_5678, 1'b0);
    run32(MDU_MULT, 32'd3, 32'd4, 1'b0, 10, 0);
    run32(MDU_DIVU, 32'd1000, 32'd7, 1'b0, 0, 5);
    run32(MDU_MULT, 32'd9, 32'd9, 1'b0, 33, 0);
    mt32(MDU_MTHI, 32'h0000_1111, 1'b1);
    mt32(MDU_MULT, 32'd5, 1'b1);
    mt32(3'd6, 32'h0000_0077, 1'b0);
    mt32(3'd7, 32'h0000_0088, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; a = 32'd12345; b = 32'd678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    hm = '0;
    lm = '0;

    for (int i = 0; i < 30; i++) begin
      o  = 3'($urandom_range(0, 5));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = 32'd0;
        1: bv = 32'hFFFF_FFFF;
        2: bv = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) av = 32'h8000_0000;
      if (o >= 3'd4) mt32(o, av, 1'b0);
      else run32(o, av, bv, 1'($urandom_range(0, 1)), 0, 0);
    end

    run8(MDU_MULT, 8'h80, 8'hFF, 1'b0);
    run8(MDU_DIV,  8'h07, 8'hFE, 1'b1);
    run8(MDU_DIVU, 8'hC8, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) begin
      run8(3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
